// File: rtl/dmp_pkg.sv
// Shared types for the pagerank deserializer: lane word, FSM states, saturation limit.
// Pure declarations; no timing and no flow control.
// No backpressure: consumers use these types directly.
package dmp_pkg;

    typedef logic [63:0] dmp_rank_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        NEXT  = 2'd3
    } deser_state_t;

    localparam dmp_rank_t RANK_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/dmp_lane_acc.sv
// One 64-bit accumulator lane with clear and enable; saturates when DMP_DESERIAL_SAT_EN is defined, else wraps.
// Latency: an enabled add is visible one edge later.
// No backpressure: accepts every enabled add.
module dmp_lane_acc
    import dmp_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      i_clr,
    input  logic      i_en,
    input  dmp_rank_t i_add,
    output dmp_rank_t o_acc
);

    dmp_rank_t r_acc;
    dmp_rank_t w_next;

`ifdef DMP_DESERIAL_SAT_EN
    logic [64:0] w_sum;
    assign w_sum  = {1'b0, r_acc} + {1'b0, i_add};
    assign w_next = w_sum[64] ? RANK_MAX : w_sum[63:0];
`else
    assign w_next = r_acc + i_add;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dmp_deserial.sv
// Sums one packet per thread per node between stream start and done, holds the result until acked, then pulses nextIteration.
// Latency: packet visible after its edge; result_valid the cycle after done; nextIteration the cycle after ack. Lane add mode: DMP_DESERIAL_SAT_EN.
// No backpressure: packets beyond NUM_HW_THREADS are dropped and flagged via count_error.
module dmp_deserial
    import dmp_pkg::*;
#(
    parameter int NUM_HW_THREADS = 8,
    parameter int NODES_IN_GRAPH = 32
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      stream_start,
    input  logic      stream_valid,
    input  logic      stream_done,
    input  dmp_rank_t stream_in [NODES_IN_GRAPH],
    input  logic      result_ack,
    output dmp_rank_t pagerank_out [NODES_IN_GRAPH],
    output logic      result_valid,
    output logic      count_error,
    output logic      nextIteration
);

    localparam int CW = $clog2(NUM_HW_THREADS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_HW_THREADS);

    deser_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic w_full;
    logic w_clr;
    logic w_en;

    assign w_full = (r_cnt == CNT_FULL);
    assign w_clr  = (r_state == IDLE) && stream_start;
    // done wins over a packet arriving on the same cycle
    assign w_en   = (r_state == ACCUM) && !stream_done && stream_valid && !w_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (stream_start) begin
                        r_state <= ACCUM;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (stream_done) begin
                        r_state <= HOLD;
                        if (!w_full) begin
                            r_err <= 1'b1;
                        end
                    end else if (stream_valid) begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (result_ack) begin
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NODES_IN_GRAPH; g++) begin : g_lane
        dmp_lane_acc u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .i_clr   (w_clr),
            .i_en    (w_en),
            .i_add   (stream_in[g]),
            .o_acc   (pagerank_out[g])
        );
    end

    assign result_valid  = (r_state == HOLD);
    assign nextIteration = (r_state == NEXT);
    assign count_error   = r_err;

endmodule

// File: tb/tb_dmp_deserial.sv
// Randomized and directed bench for dmp_deserial with 2 threads and 4 nodes.
// Expected sums come from a packet-list model: the first NUM_HW_THREADS packets of each stream, added per lane.
module tb_dmp_deserial;

    localparam int T = 2;
    localparam int N = 4;
    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stream_start = 1'b0;
    logic        stream_valid = 1'b0;
    logic        stream_done = 1'b0;
    logic        result_ack = 1'b0;
    logic [63:0] stream_in [N];
    logic [63:0] pagerank_out [N];
    logic        result_valid;
    logic        count_error;
    logic        nextIteration;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_acc [N];
    int          sent;

    always #5 clock = ~clock;

    dmp_deserial #(
        .NUM_HW_THREADS (T),
        .NODES_IN_GRAPH (N)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stream_start  (stream_start),
        .stream_valid  (stream_valid),
        .stream_done   (stream_done),
        .stream_in     (stream_in),
        .result_ack    (result_ack),
        .pagerank_out  (pagerank_out),
        .result_valid  (result_valid),
        .count_error   (count_error),
        .nextIteration (nextIteration)
    );

    function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
`ifdef DMP_DESERIAL_SAT_EN
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, MAXV}) ? MAXV : s[63:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [63:0] rnd64();
        if ($urandom_range(0, 2) == 0) return ~64'($urandom_range(0, 3));
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_stream();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        for (int i = 0; i < N; i++) exp_acc[i] = '0;
        sent = 0;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] d);
        stream_in = '{a, b, c, d};
        stream_valid = 1'b1;
        tick();
        stream_valid = 1'b0;
        if (sent < T) for (int i = 0; i < N; i++) exp_acc[i] = lane_add(exp_acc[i], stream_in[i]);
        sent++;
    endtask

    task automatic end_stream();
        stream_done = 1'b1;
        tick();
        stream_done = 1'b0;
    endtask

    task automatic ack_and_idle();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) stream_in[i] = '0;
        reset_n = 1'b0;
        #12;
        checks++;
        if ({result_valid, count_error, nextIteration} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000", {result_valid, count_error, nextIteration});
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== 64'd0) begin
                errors++;
                $display("FAIL reset_lane%0d got %h exp 0", i, pagerank_out[i]);
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        start_stream();
        send(1, 2, 3, 4);
        send(10, 20, 30, 40);
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL nom_rv_early got %b exp 0", result_valid);
        end
        end_stream();
        checks++;
        if (result_valid !== 1'b1 || count_error !== 1'b0) begin
            errors++;
            $display("FAIL nom_flags got rv=%b err=%b exp rv=1 err=0", result_valid, count_error);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== exp_acc[i] || pagerank_out[i] !== 64'(11 * (i + 1))) begin
                errors++;
                $display("FAIL nom_lane%0d got %0d exp %0d", i, pagerank_out[i], 11 * (i + 1));
            end
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if (nextIteration !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL nom_pulse got ni=%b rv=%b exp ni=1 rv=0", nextIteration, result_valid);
        end
        tick();
        checks++;
        if (nextIteration !== 1'b0) begin
            errors++;
            $display("FAIL nom_pulse_end got %b exp 0", nextIteration);
        end
    endtask

    task automatic test_short();
        start_stream();
        send(5, 5, 5, 5);
        end_stream();
        checks++;
        if (count_error !== 1'b1 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL short_flags got err=%b rv=%b exp 1 1", count_error, result_valid);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== exp_acc[i]) begin
                errors++;
                $display("FAIL short_lane%0d got %0d exp %0d", i, pagerank_out[i], exp_acc[i]);
            end
        end
        ack_and_idle();
        checks++;
        if (count_error !== 1'b1) begin
            errors++;
            $display("FAIL short_sticky got %b exp 1", count_error);
        end
        start_stream();
        checks++;
        if (count_error !== 1'b0) begin
            errors++;
            $display("FAIL short_clear got %b exp 0", count_error);
        end
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);
        end_stream();
        ack_and_idle();
    endtask

    task automatic test_extra();
        start_stream();
        send(1, 1, 1, 1);
        send(1, 1, 1, 1);
        checks++;
        if (count_error !== 1'b0) begin
            errors++;
            $display("FAIL extra_pre got %b exp 0", count_error);
        end
        send(1, 1, 1, 1);
        checks++;
        if (count_error !== 1'b1) begin
            errors++;
            $display("FAIL extra_flag got %b exp 1", count_error);
        end
        end_stream();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== 64'd2) begin
                errors++;
                $display("FAIL extra_lane%0d got %0d exp 2", i, pagerank_out[i]);
            end
        end
        ack_and_idle();
    endtask

    task automatic test_overflow();
        logic [63:0] want0;
`ifdef DMP_DESERIAL_SAT_EN
        want0 = MAXV;
`else
        want0 = 64'd1;
`endif
        start_stream();
        send(MAXV, 0, 0, 0);
        send(2, 1, 1, 1);
        end_stream();
        checks++;
        if (pagerank_out[0] !== want0) begin
            errors++;
            $display("FAIL ovf_lane0 got %h exp %h", pagerank_out[0], want0);
        end
        checks++;
        if (pagerank_out[1] !== 64'd1) begin
            errors++;
            $display("FAIL ovf_lane1 got %h exp 1", pagerank_out[1]);
        end
        ack_and_idle();
    endtask

    task automatic test_priority_and_hold();
        logic [63:0] snap [N];
        start_stream();
        send(1, 1, 1, 1);
        stream_in = '{64'd100, 64'd100, 64'd100, 64'd100};
        stream_valid = 1'b1;
        stream_done = 1'b1;
        tick();
        stream_valid = 1'b0;
        stream_done = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || count_error !== 1'b1) begin
            errors++;
            $display("FAIL prio_flags got rv=%b err=%b exp 1 1", result_valid, count_error);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== exp_acc[i]) begin
                errors++;
                $display("FAIL prio_lane%0d got %0d exp %0d", i, pagerank_out[i], exp_acc[i]);
            end
            snap[i] = exp_acc[i];
        end
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        tick();
        checks++;
        if (result_valid !== 1'b1 || nextIteration !== 1'b0) begin
            errors++;
            $display("FAIL hold_start got rv=%b ni=%b exp 1 0", result_valid, nextIteration);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== snap[i]) begin
                errors++;
                $display("FAIL hold_lane%0d got %0d exp %0d", i, pagerank_out[i], snap[i]);
            end
        end
        ack_and_idle();
    endtask

    task automatic test_ack_ignored();
        result_ack = 1'b1;
        tick();
        checks++;
        if (nextIteration !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle got ni=%b rv=%b exp 0 0", nextIteration, result_valid);
        end
        start_stream();
        tick();
        checks++;
        if (nextIteration !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_accum got ni=%b rv=%b exp 0 0", nextIteration, result_valid);
        end
        result_ack = 1'b0;
        end_stream();
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_then_hold got rv=%b exp 1", result_valid);
        end
        ack_and_idle();
    endtask

    task automatic test_reset_midstream();
        start_stream();
        send(7, 7, 7, 7);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({result_valid, count_error, nextIteration} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_flags got %b exp 000", {result_valid, count_error, nextIteration});
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== 64'd0) begin
                errors++;
                $display("FAIL midrst_lane%0d got %0d exp 0", i, pagerank_out[i]);
            end
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (nextIteration !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_pulse got %b exp 0", nextIteration);
        end
        start_stream();
        send(3, 4, 5, 6);
        send(1, 1, 1, 1);
        end_stream();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pagerank_out[i] !== exp_acc[i]) begin
                errors++;
                $display("FAIL midrst_sum%0d got %0d exp %0d", i, pagerank_out[i], exp_acc[i]);
            end
        end
        ack_and_idle();
    endtask

    task automatic test_random();
        int npk;
        for (int it = 0; it < 25; it++) begin
            start_stream();
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
                if ($urandom_range(0, 1) == 1) tick();
                send(rnd64(), rnd64(), rnd64(), rnd64());
            end
            end_stream();
            checks++;
            if (result_valid !== 1'b1 || count_error !== (npk != T)) begin
                errors++;
                $display("FAIL rnd%0d_flags got rv=%b err=%b exp rv=1 err=%b", it, result_valid,
                         count_error, (npk != T));
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (pagerank_out[i] !== exp_acc[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_lane%0d got %h exp %h", it, i, pagerank_out[i], exp_acc[i]);
                end
            end
            result_ack = 1'b1;
            tick();
            result_ack = 1'b0;
            checks++;
            if (nextIteration !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_pulse got %b exp 1", it, nextIteration);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_extra();
        test_overflow();
        test_priority_and_hold();
        test_ack_ignored();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
